// File: rtl/fht_but_ctrl.sv
// FHT stage/sector sequencer: read addressing, butterfly control and write-back delay.
// Optional FHT_CTRL_HOLD_EN adds iHOLD to stretch the inter-stage gap.
module fht_but_ctrl #(
  parameter int A_BIT   = 8,
  parameter int S_BIT   = 4,
  parameter int STAGES  = A_BIT + 1,
  parameter int BUT_LAT = 3
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
`ifdef FHT_CTRL_HOLD_EN
  input  logic             iHOLD,
`endif
  output logic             oBUSY,
  output logic             oDONE,
  output logic [S_BIT-1:0] oSTAGE,
  output logic             oST_ZERO,
  output logic             oST_LAST,
  output logic [A_BIT-1:0] oSECTOR,
  output logic             o2ND_PART_SUBSEC,
  output logic             oWR_2ND,
  output logic [A_BIT-1:0] oROM_ADDR,
  output logic [A_BIT-1:0] oRD_ADDR,
  output logic             oRD_EN,
  output logic [A_BIT-1:0] oWR_ADDR,
  output logic             oWE
);

  localparam int DW = $clog2(BUT_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    GAP,
    DONE
  } state_t;

  state_t           state;
  logic [S_BIT-1:0] s;
  logic [A_BIT-1:0] cnt;
  logic [DW-1:0]    dcnt;
  logic             hold;

  logic [BUT_LAT-1:0] vld_q;
  logic [A_BIT-1:0]   adr_q [BUT_LAT];
  logic [BUT_LAT-2:0] sec_q;

  logic             rd;
  logic             half;
  logic [A_BIT-1:0] sec;
  logic [A_BIT-1:0] mask;
  logic [A_BIT-1:0] rom;
  logic [A_BIT-1:0] hs;
  logic [S_BIT-1:0] rom_sh;

`ifdef FHT_CTRL_HOLD_EN
  assign hold = iHOLD;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
      s     <= '0;
      cnt   <= '0;
      dcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iSTART) begin
            state <= READ;
            s     <= '0;
            cnt   <= '0;
          end
        end
        READ: begin
          if (&cnt) begin
            state <= DRAIN;
            cnt   <= '0;
            dcnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == DW'(BUT_LAT - 1))
            state <= GAP;
          else
            dcnt <= dcnt + 1'b1;
        end
        GAP: begin
          if (!hold) begin
            if (s == S_BIT'(STAGES - 1)) begin
              state <= DONE;
              s     <= '0;
            end else begin
              state <= READ;
              s     <= s + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // write-back pipe mirrors the butterfly latency
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      vld_q <= '0;
      sec_q <= '0;
      for (int i = 0; i < BUT_LAT; i++)
        adr_q[i] <= '0;
    end else begin
      vld_q[0] <= rd;
      adr_q[0] <= oRD_ADDR;
      sec_q[0] <= half;
      for (int i = 1; i < BUT_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        adr_q[i] <= adr_q[i-1];
      end
      for (int i = 1; i < BUT_LAT - 1; i++)
        sec_q[i] <= sec_q[i-1];
    end
  end

  assign rd     = (state == READ);
  assign sec    = cnt >> s;
  assign mask   = ~({A_BIT{1'b1}} << s);
  assign rom_sh = S_BIT'(A_BIT) - s;
  assign rom    = (cnt & mask) << rom_sh;
  assign hs     = cnt >> (s - 1'b1);
  assign half   = rd && (s != '0) && hs[0];

  assign oBUSY            = (state == READ) || (state == DRAIN) ||
                            (state == GAP);
  assign oDONE            = (state == DONE);
  assign oSTAGE           = s;
  assign oST_ZERO         = rd && (s == '0);
  assign oST_LAST         = rd && (s == S_BIT'(STAGES - 1));
  assign oSECTOR          = rd ? sec : '0;
  assign o2ND_PART_SUBSEC = half;
  assign oROM_ADDR        = rd ? rom : '0;
  assign oRD_ADDR         = rd ? cnt : '0;
  assign oRD_EN           = rd;
  assign oWE              = vld_q[BUT_LAT-1];
  assign oWR_ADDR         = adr_q[BUT_LAT-1];
  assign oWR_2ND          = sec_q[BUT_LAT-2];

endmodule

// File: tb/tb_fht_but_ctrl.sv
// Directed bench for fht_but_ctrl with A_BIT=2, BUT_LAT=3.
// Hold scenario is exercised when FHT_CTRL_HOLD_EN is defined.
module tb_fht_but_ctrl;

  logic       iCLK = 1'b0;
  logic       iRESET;
  logic       iSTART;
`ifdef FHT_CTRL_HOLD_EN
  logic       iHOLD;
`endif
  logic       oBUSY;
  logic       oDONE;
  logic [3:0] oSTAGE;
  logic       oST_ZERO;
  logic       oST_LAST;
  logic [1:0] oSECTOR;
  logic       o2ND_PART_SUBSEC;
  logic       oWR_2ND;
  logic [1:0] oROM_ADDR;
  logic [1:0] oRD_ADDR;
  logic       oRD_EN;
  logic [1:0] oWR_ADDR;
  logic       oWE;

  int n_asrt = 0;
  int n_fail = 0;

  int half_t [3][4] = '{'{0,0,0,0}, '{0,1,0,1}, '{0,0,1,1}};
  int sect_t [3][4] = '{'{0,1,2,3}, '{0,0,1,1}, '{0,0,0,0}};
  int rom_t  [3][4] = '{'{0,0,0,0}, '{0,2,0,2}, '{0,1,2,3}};

  fht_but_ctrl #(
    .A_BIT(2),
    .S_BIT(4),
    .BUT_LAT(3)
  ) dut (
    .iCLK(iCLK),
    .iRESET(iRESET),
    .iSTART(iSTART),
`ifdef FHT_CTRL_HOLD_EN
    .iHOLD(iHOLD),
`endif
    .oBUSY(oBUSY),
    .oDONE(oDONE),
    .oSTAGE(oSTAGE),
    .oST_ZERO(oST_ZERO),
    .oST_LAST(oST_LAST),
    .oSECTOR(oSECTOR),
    .o2ND_PART_SUBSEC(o2ND_PART_SUBSEC),
    .oWR_2ND(oWR_2ND),
    .oROM_ADDR(oROM_ADDR),
    .oRD_ADDR(oRD_ADDR),
    .oRD_EN(oRD_EN),
    .oWR_ADDR(oWR_ADDR),
    .oWE(oWE)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, oBUSY, 0);
    chk({tag, " done"}, oDONE, 0);
    chk({tag, " stage"}, oSTAGE, 0);
    chk({tag, " st_zero"}, oST_ZERO, 0);
    chk({tag, " st_last"}, oST_LAST, 0);
    chk({tag, " sector"}, oSECTOR, 0);
    chk({tag, " half"}, o2ND_PART_SUBSEC, 0);
    chk({tag, " wr_2nd"}, oWR_2ND, 0);
    chk({tag, " rom"}, oROM_ADDR, 0);
    chk({tag, " rd_addr"}, oRD_ADDR, 0);
    chk({tag, " rd_en"}, oRD_EN, 0);
    chk({tag, " wr_addr"}, oWR_ADDR, 0);
    chk({tag, " we"}, oWE, 0);
  endtask

  initial begin
    iRESET = 1'b1;
    iSTART = 1'b0;
`ifdef FHT_CTRL_HOLD_EN
    iHOLD  = 1'b0;
`endif
    tick();
    tick();
    chk_idle("reset");
    iRESET = 1'b0;
    tick();
    tick();
    chk_idle("idle");

    // full transform, cycle-by-cycle
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      int  p, st, ws;
      bit  last, rd, we, w2;
      string t;
      p    = (c - 1) % 8;
      st   = (c - 1) / 8;
      last = (c == 25);
      rd   = !last && p < 4;
      we   = !last && p >= 3 && p <= 6;
      w2   = !last && p >= 2 && p <= 5;
      ws   = last ? 0 : st;
      t    = $sformatf("c%0d", c);
      chk({t, " busy"}, oBUSY, !last);
      chk({t, " done"}, oDONE, last);
      chk({t, " stage"}, oSTAGE, ws);
      chk({t, " rd_en"}, oRD_EN, rd);
      chk({t, " rd_addr"}, oRD_ADDR, rd ? p : 0);
      chk({t, " st_zero"}, oST_ZERO, rd && st == 0);
      chk({t, " st_last"}, oST_LAST, rd && st == 2);
      chk({t, " half"}, o2ND_PART_SUBSEC, rd ? half_t[st][p] : 0);
      chk({t, " sector"}, oSECTOR, rd ? sect_t[st][p] : 0);
      chk({t, " rom"}, oROM_ADDR, rd ? rom_t[st][p] : 0);
      chk({t, " we"}, oWE, we);
      chk({t, " wr_addr"}, oWR_ADDR, we ? p - 3 : 0);
      chk({t, " wr_2nd"}, oWR_2ND, w2 ? half_t[st][p-2] : 0);
      tick();
    end
    chk_idle("c26");

    // start held high: one transform, then restart after done
    iSTART = 1'b1;
    tick();
    for (int c = 1; c <= 25; c++) begin
      string t;
      t = $sformatf("hs c%0d", c);
      chk({t, " busy"}, oBUSY, c != 25);
      chk({t, " done"}, oDONE, c == 25);
      tick();
    end
    chk("hs c26 busy", oBUSY, 0);
    chk("hs c26 rd_en", oRD_EN, 0);
    tick();
    chk("hs c27 busy", oBUSY, 1);
    chk("hs c27 rd_en", oRD_EN, 1);
    chk("hs c27 rd_addr", oRD_ADDR, 0);
    chk("hs c27 st_zero", oST_ZERO, 1);
    iSTART = 1'b0;

    // reset mid-drain of the restarted transform
    for (int i = 0; i < 5; i++)
      tick();
    chk("rst c6 we", oWE, 1);
    chk("rst c6 wr_addr", oWR_ADDR, 2);
    iRESET = 1'b1;
    tick();
    iRESET = 1'b0;
    chk_idle("rst c7");
    for (int i = 0; i < 30; i++) begin
      tick();
      chk($sformatf("post-rst %0d done", i), oDONE, 0);
      chk($sformatf("post-rst %0d we", i), oWE, 0);
      chk($sformatf("post-rst %0d busy", i), oBUSY, 0);
    end

    // start together with reset is dropped
    iRESET = 1'b1;
    iSTART = 1'b1;
    tick();
    iRESET = 1'b0;
    iSTART = 1'b0;
    chk("rst+start busy", oBUSY, 0);
    chk("rst+start rd_en", oRD_EN, 0);
    tick();
    chk_idle("rst+start next");

`ifdef FHT_CTRL_HOLD_EN
    iSTART = 1'b1;
    tick();
    iSTART = 1'b0;
    for (int i = 0; i < 7; i++)
      tick();
    chk("hold c8 busy", oBUSY, 1);
    chk("hold c8 rd_en", oRD_EN, 0);
    iHOLD = 1'b1;
    for (int i = 0; i < 5; i++)
      tick();
    iHOLD = 1'b0;
    chk("hold c13 busy", oBUSY, 1);
    chk("hold c13 rd_en", oRD_EN, 0);
    chk("hold c13 stage", oSTAGE, 0);
    tick();
    chk("hold c14 rd_en", oRD_EN, 1);
    chk("hold c14 stage", oSTAGE, 1);
    chk("hold c14 rd_addr", oRD_ADDR, 0);
    for (int i = 0; i < 15; i++)
      tick();
    chk("hold c29 busy", oBUSY, 1);
    chk("hold c29 done", oDONE, 0);
    tick();
    chk("hold c30 done", oDONE, 1);
    chk("hold c30 busy", oBUSY, 0);
    tick();
    chk_idle("hold c31");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
